seg7_scan_scheduler: RTL and testbench

Time-multiplexes an 8-digit, common-anode, active-low 7-segment display from a double-buffered digit store.
- A writer loads hex digits and decimal points into a shadow buffer through a valid/ready port.
- A commit request copies the shadow buffer to the active buffer at the next frame boundary, so the display never tears.
- The scan FSM inserts anode dead-time between digits to prevent ghosting.
- Sits between the counter/status logic and the board seg/an pins.

---
 rtl/seg7_scan_scheduler_if.sv | 21 ++
 rtl/seg7_scan_scheduler.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_scheduler_if.sv
// Write/commit port of the 7-segment scan scheduler.
// The writer uses master; the scheduler uses slave.
interface seg7_scan_scheduler_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic       commit_pending;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_dp, commit,
        input  wr_ready, commit_pending
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_dp, commit,
        output wr_ready, commit_pending
    );
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Multiplexed 8-digit active-low 7-segment driver.
// Uses a shadow/active digit store and inserts anode dead-time between digits.
module seg7_scan_scheduler #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  lz_blank,
    seg7_scan_scheduler_if.slave  wr,
    output logic                  frame_done,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [7:0]            an
);
    localparam int unsigned CMAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     idx_q, idx_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [7:0]                     an_q, an_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;
    logic                           fd_q, fd_d;
    logic                           pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0]     sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]          sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]          lz_mask;
    logic                           last_drive, frame_end, apply, wr_fire;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        lz_mask = '0;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            lead = lead & (act_val_q[k-1] == 4'd0);
            if (k > 1) lz_mask[k-1] = lead & lz_blank;
        end
    end

    always_comb begin
        last_drive = (state_q == DRIVE) && (cnt_q == CW'(SCAN_CYCLES - 1));
        frame_end  = last_drive && (idx_q == 3'(NUM_DIGITS - 1));
        apply      = pending_q && (frame_end || state_q == IDLE);
        wr_fire    = wr.wr_valid && !apply && ({29'd0, wr.wr_addr} < NUM_DIGITS);

        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        if (wr_fire) begin
            sh_val_d[wr.wr_addr] = wr.wr_data;
            sh_dp_d[wr.wr_addr]  = wr.wr_dp;
        end
        act_val_d = apply ? sh_val_q : act_val_q;
        act_dp_d  = apply ? sh_dp_q  : act_dp_q;
        // A commit seen on the applying cycle re-arms for the next frame end.
        pending_d = apply ? wr.commit : (pending_q | wr.commit);

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        fd_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            an_d    = '1;
            seg_d   = '1;
            dp_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = '1;
                    dp_d    = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        an_d    = ~(8'd1 << idx_q);
                        seg_d   = lz_mask[idx_q] ? 7'h7F : hex7(act_val_q[idx_q]);
                        dp_d    = ~act_dp_q[idx_q];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DRIVE: begin
                    if (last_drive) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        an_d    = '1;
                        seg_d   = '1;
                        dp_d    = 1'b1;
                        if (frame_end) begin
                            idx_d = '0;
                            fd_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            an_q      <= '1;
            seg_q     <= '1;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
            pending_q <= 1'b0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
            pending_q <= pending_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
        end
    end

    assign wr.wr_ready       = ~apply;
    assign wr.commit_pending = pending_q;
    assign frame_done        = fd_q;
    assign seg               = seg_q;
    assign dp                = dp_q;
    assign an                = an_q;
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Scoreboard bench for seg7_scan_scheduler: expected digit displays are queued by
// the stimulus and popped by a monitor at the start of every DRIVE period.
module tb_seg7_scan_scheduler;
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SOFF = 7'h7F;

    logic       clk = 1'b0;
    logic       reset, enable, lz_blank;
    logic       frame_done, dp;
    logic [6:0] seg;
    logic [7:0] an;

    seg7_scan_scheduler_if wr();

    seg7_scan_scheduler #(
        .NUM_DIGITS  (8),
        .SCAN_CYCLES (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .lz_blank  (lz_blank),
        .wr        (wr),
        .frame_done(frame_done),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    disp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // s and dpl hold digit i at slice i; dpl is the active-low dp value.
    task automatic push_frame(input logic [7:0][6:0] s, input logic [7:0] dpl, input int n);
        disp_t e;
        for (int i = 0; i < n; i++) begin
            e.an    = 8'hFF;
            e.an[i] = 1'b0;
            e.seg   = s[i];
            e.dp    = dpl[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
    endtask

    task automatic set_wr(input logic v, input logic [2:0] a, input logic [3:0] d, input logic p);
        wr.wr_valid = v;
        wr.wr_addr  = a;
        wr.wr_data  = d;
        wr.wr_dp    = p;
    endtask

    initial begin : monitor
        logic [7:0] prev;
        disp_t      e;
        prev = 8'hFF;
        forever begin
            @(negedge clk);
            if (an !== 8'hFF && an !== prev && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("disp{an,seg,dp}", {16'd0, an, seg, dp}, {16'd0, e});
            end
            prev = an;
        end
    end

    initial begin : stim
        int n;
        reset = 1'b1; enable = 1'b0; lz_blank = 1'b0; wr.commit = 1'b0;
        set_wr(1'b0, 3'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_pending", wr.commit_pending, 0);
        check("rst_wr_ready", wr.wr_ready, 1);

        // Free-running scan of zeros.
        push_frame({8{S0}}, 8'hFF, 8);
        reset = 1'b0; enable = 1'b1;
        wait_fd(n);
        check("first_frame_done", n, 49);

        // Frame A: load 5 and A.dp into shadow, commit; display stays zero.
        push_frame({8{S0}}, 8'hFF, 8);
        set_wr(1'b1, 3'd0, 4'h5, 1'b0);
        @(negedge clk);
        check("fd_one_cycle", frame_done, 0);
        set_wr(1'b1, 3'd1, 4'hA, 1'b1);
        @(negedge clk);
        set_wr(1'b0, 3'd0, 4'd0, 1'b0);
        wr.commit = 1'b1;
        @(negedge clk);
        wr.commit = 1'b0;
        check("pending_set", wr.commit_pending, 1);
        wait_fd(n);
        check("frame_period_a", n, 45);
        check("pending_cleared", wr.commit_pending, 0);

        // Frame B shows the commit; load {3,0,7} with a same-cycle write+commit.
        push_frame({S0, S0, S0, S0, S0, S0, SA, S5}, 8'b1111_1101, 8);
        set_wr(1'b1, 3'd0, 4'h7, 1'b0);
        @(negedge clk);
        set_wr(1'b1, 3'd1, 4'h0, 1'b0);
        @(negedge clk);
        set_wr(1'b1, 3'd2, 4'h3, 1'b0);
        wr.commit = 1'b1;
        @(negedge clk);
        set_wr(1'b0, 3'd0, 4'd0, 1'b0);
        wr.commit = 1'b0;
        wait_fd(n);
        check("frame_period_b", n, 45);

        // Frame C with leading-zero blanking.
        lz_blank = 1'b1;
        push_frame({SOFF, SOFF, SOFF, SOFF, SOFF, S3, S0, S7}, 8'hFF, 8);
        wait_fd(n);
        check("frame_period_c", n, 48);

        // Frame D: zeros drawn; write held across the frame-end cycle.
        lz_blank = 1'b0;
        push_frame({S0, S0, S0, S0, S0, S3, S0, S7}, 8'hFF, 8);
        wr.commit = 1'b1;
        @(negedge clk);
        wr.commit = 1'b0;
        for (int c = 2; c <= 47; c++) begin
            @(negedge clk);
            if (c == 46) check("wr_ready_before_end", wr.wr_ready, 1);
            if (c == 47) begin
                check("wr_ready_frame_end", wr.wr_ready, 0);
                check("pending_before_end", wr.commit_pending, 1);
                set_wr(1'b1, 3'd3, 4'h9, 1'b1);
            end
        end
        @(negedge clk);
        check("fd_after_end", frame_done, 1);
        check("wr_ready_after_end", wr.wr_ready, 1);
        check("pending_after_end", wr.commit_pending, 0);

        // Frame E: shadow-only 9 not shown; disable during DRIVE(3).
        push_frame({S0, S0, S0, S0, S0, S3, S0, S7}, 8'hFF, 4);
        @(negedge clk);
        set_wr(1'b0, 3'd0, 4'd0, 1'b0);
        for (int c = 2; c <= 21; c++) @(negedge clk);
        check("drive3_an", an, 8'hF7);
        enable = 1'b0;
        @(negedge clk);
        check("idle_an", an, 8'hFF);
        check("idle_seg", seg, 7'h7F);
        check("idle_dp", dp, 1);
        wr.commit = 1'b1;
        @(negedge clk);
        wr.commit = 1'b0;
        check("idle_pending", wr.commit_pending, 1);
        check("idle_apply_ready", wr.wr_ready, 0);
        @(negedge clk);
        check("idle_applied", wr.commit_pending, 0);
        check("idle_ready_back", wr.wr_ready, 1);
        push_frame({S0, S0, S0, S0, S9, S3, S0, S7}, 8'b1111_0111, 8);
        enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("restart_blank_an", an, 8'hFF);
            check("restart_no_fd", frame_done, 0);
        end
        wait_fd(n);
        check("restart_period", n, 47);

        // Frame H: reset during DRIVE(5) with a commit pending.
        push_frame({S0, S0, S0, S0, S9, S3, S0, S7}, 8'b1111_0111, 6);
        wr.commit = 1'b1;
        @(negedge clk);
        wr.commit = 1'b0;
        for (int c = 2; c <= 32; c++) @(negedge clk);
        check("drive5_an", an, 8'hDF);
        check("pending_before_rst", wr.commit_pending, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_an", an, 8'hFF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dp", dp, 1);
        check("async_rst_pending", wr.commit_pending, 0);
        repeat (2) @(negedge clk);
        push_frame({8{S0}}, 8'hFF, 8);
        reset = 1'b0;
        wait_fd(n);
        check("post_rst_frame_done", n, 49);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
